// File: rtl/i2c_register_reader.sv
// i2c_register_reader
// Autonomous I2C master client: claims one arbiter port, writes a register
// pointer, issues a repeated start and reads back N bytes, then releases the
// port. Requesters supply only device address, register address and length.

package i2c_reader_pkg;

    // Command bundle towards the shared transceiver.
    typedef struct packed {
        logic       start;
        logic       restart;
        logic       stop;
        logic       tx_en;
        logic [7:0] tx_data;
        logic       rx_en;
        logic       rx_ack;
    } i2c_in_t;

    // Status bundle from the shared transceiver.
    typedef struct packed {
        logic       busy;
        logic       rx_rdy;
        logic [7:0] rx_out;
        logic       tx_ack;
    } i2c_out_t;

endpackage

module i2c_register_reader
    import i2c_reader_pkg::*;
#(
    parameter int LEN_BITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [6:0]          dev_addr,
    input  logic [7:0]          reg_addr,
    input  logic [LEN_BITS-1:0] len,
    output logic                busy,
    output logic                done,
    output logic                nak,
    output logic                rd_valid,
    output logic [7:0]          rd_data,
    output logic [LEN_BITS-1:0] rd_index,
    output logic                driver_request,
    input  logic                driver_ack,
    output logic                driver_done,
    output i2c_in_t             driver_cin,
    input  i2c_out_t            driver_cout
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_REQ,
        S_GRANT,
        S_START,
        S_ADDR_W,
        S_REG,
        S_RESTART,
        S_ADDR_R,
        S_READ,
        S_STOP,
        S_RELEASE
    } state_e;

    // Sub-phase shared by every bus-operation state: the command cycle, one
    // cycle where transceiver busy is not yet trusted, then wait for idle.
    typedef enum logic [1:0] {
        PH_CMD,
        PH_SKIP,
        PH_WAIT
    } phase_e;

    state_e              state_q;
    phase_e              phase_q;
    logic [6:0]          dev_q;
    logic [7:0]          reg_q;
    logic [LEN_BITS-1:0] len_q;
    logic [LEN_BITS-1:0] count_q;
    logic                nak_q;

    // Transaction sequencer; every output is a register driven from here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            phase_q        <= PH_CMD;
            dev_q          <= '0;
            reg_q          <= '0;
            len_q          <= '0;
            count_q        <= '0;
            nak_q          <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            nak            <= 1'b0;
            rd_valid       <= 1'b0;
            rd_data        <= '0;
            rd_index       <= '0;
            driver_request <= 1'b0;
            driver_done    <= 1'b0;
            driver_cin     <= '0;
        end else begin
            // Pulses and commands default low; states override for one cycle.
            driver_request <= 1'b0;
            driver_done    <= 1'b0;
            done           <= 1'b0;
            nak            <= 1'b0;
            rd_valid       <= 1'b0;
            driver_cin     <= '0;

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (len != '0) begin
                            dev_q          <= dev_addr;
                            reg_q          <= reg_addr;
                            len_q          <= len;
                            count_q        <= '0;
                            nak_q          <= 1'b0;
                            busy           <= 1'b1;
                            driver_request <= 1'b1;
                            state_q        <= S_REQ;
                        end else begin
                            // Nothing to read: finish without touching the bus.
                            done <= 1'b1;
                        end
                    end
                end

                S_REQ: begin
                    state_q <= S_GRANT;
                end

                S_GRANT: begin
                    if (driver_ack) begin
                        driver_cin.start <= 1'b1;
                        phase_q          <= PH_CMD;
                        state_q          <= S_START;
                    end
                end

                S_RELEASE: begin
                    busy    <= 1'b0;
                    state_q <= S_IDLE;
                end

                default: begin
                    if (phase_q == PH_CMD) begin
                        phase_q <= PH_SKIP;
                    end else if (state_q == S_READ && driver_cout.rx_rdy &&
                                 count_q != len_q) begin
                        // Byte capture has priority; advancing happens on a
                        // later cycle so count_q is settled for rx_ack.
                        rd_valid <= 1'b1;
                        rd_data  <= driver_cout.rx_out;
                        rd_index <= count_q;
                        count_q  <= count_q + LEN_BITS'(1);
                        phase_q  <= PH_WAIT;
                    end else if (phase_q == PH_SKIP) begin
                        phase_q <= PH_WAIT;
                    end else if (!driver_cout.busy) begin
                        phase_q <= PH_CMD;
                        case (state_q)
                            S_START: begin
                                driver_cin.tx_en   <= 1'b1;
                                driver_cin.tx_data <= {dev_q, 1'b0};
                                state_q            <= S_ADDR_W;
                            end
                            S_ADDR_W: begin
                                if (!driver_cout.tx_ack) begin
                                    nak_q           <= 1'b1;
                                    driver_cin.stop <= 1'b1;
                                    state_q         <= S_STOP;
                                end else begin
                                    driver_cin.tx_en   <= 1'b1;
                                    driver_cin.tx_data <= reg_q;
                                    state_q            <= S_REG;
                                end
                            end
                            S_REG: begin
                                if (!driver_cout.tx_ack) begin
                                    nak_q           <= 1'b1;
                                    driver_cin.stop <= 1'b1;
                                    state_q         <= S_STOP;
                                end else begin
                                    driver_cin.restart <= 1'b1;
                                    state_q            <= S_RESTART;
                                end
                            end
                            S_RESTART: begin
                                driver_cin.tx_en   <= 1'b1;
                                driver_cin.tx_data <= {dev_q, 1'b1};
                                state_q            <= S_ADDR_R;
                            end
                            S_ADDR_R: begin
                                if (!driver_cout.tx_ack) begin
                                    nak_q           <= 1'b1;
                                    driver_cin.stop <= 1'b1;
                                    state_q         <= S_STOP;
                                end else begin
                                    // First byte is also the last when len is 1.
                                    driver_cin.rx_en  <= 1'b1;
                                    driver_cin.rx_ack <= (len_q != LEN_BITS'(1));
                                    state_q           <= S_READ;
                                end
                            end
                            S_READ: begin
                                if (count_q == len_q) begin
                                    driver_cin.stop <= 1'b1;
                                    state_q         <= S_STOP;
                                end else begin
                                    // Master NAKs only the final byte.
                                    driver_cin.rx_en  <= 1'b1;
                                    driver_cin.rx_ack <= (count_q != len_q - LEN_BITS'(1));
                                end
                            end
                            S_STOP: begin
                                done        <= 1'b1;
                                driver_done <= 1'b1;
                                nak         <= nak_q;
                                state_q     <= S_RELEASE;
                            end
                            default: begin
                                state_q <= S_IDLE;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/i2c_register_reader.md
# i2c_register_reader

Autonomous I2C master client that performs a complete "write register pointer, repeated-start, read N bytes" transaction on behalf of simple logic, such as sensor pollers or EEPROM/ID readers. It sits directly upstream of the I2C port arbiter, using one arbiter port. It handles the arbiter request/ack/done handshake and drives the shared transceiver command interface, so requesters only supply a device address, register address and byte count.

## Interface
Parameters:
- LEN_BITS, 4: width of the byte-count input; maximum read length is 2^LEN_BITS-1 bytes.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a transaction. Ignored while busy=1.
- dev_addr  in  7  7-bit slave address; sampled on start.
- reg_addr  in  8  register pointer byte; sampled on start.
- len  in  LEN_BITS  bytes to read; sampled on start.
- busy  out  1  high from the cycle after an accepted start through the done cycle.
- done  out  1  one-cycle pulse at transaction end.
- nak  out  1  valid with done; 1 = slave NAKed the address or register byte.
- rd_valid  out  1  one-cycle pulse per received byte.
- rd_data  out  8  received byte; valid with rd_valid.
- rd_index  out  LEN_BITS  byte index (0-based) of rd_data.
- driver_request  out  1  one-cycle request pulse to the arbiter.
- driver_ack  in  1  grant pulse from the arbiter.
- driver_done  out  1  one-cycle release pulse to the arbiter.
- driver_cin  out  i2c_in_t  commands to the transceiver (start, restart, stop, tx_en, tx_data, rx_en, rx_ack).
- driver_cout  in  i2c_out_t  transceiver status (busy, rx_rdy, rx_out, tx_ack).

## Operation
- Reset: all outputs 0, driver_cin all-zero, state IDLE, counters 0.
- States: IDLE → REQ → GRANT → START → ADDR_W → REG → RESTART → ADDR_R → READ → STOP → RELEASE → IDLE.
- IDLE: on start with len≠0, latch the inputs, set busy, and go to REQ. On start with len=0, pulse done with nak=0 one cycle later; no bus activity and no request.
- REQ: pulse driver_request for one cycle, then GRANT.
- GRANT: wait indefinitely for driver_ack.
- Each bus-operation state drives its command field(s) for exactly one cycle. It then enters a shared wait sub-phase that ignores driver_cout.busy for one cycle and then waits for driver_cout.busy=0 before advancing.
- START: start=1.
- ADDR_W: tx_en=1, tx_data={dev_addr,1'b0}.
- REG: tx_en=1, tx_data=reg_addr.
- RESTART: restart=1.
- ADDR_R: tx_en=1, tx_data={dev_addr,1'b1}.
- NAK handling: after ADDR_W, REG or ADDR_R completes, if tx_ack=0, set the nak flag and jump to STOP. No read bytes are produced.
- READ: issue rx_en=1 with rx_ack=1 for every byte except the last, which gets rx_ack=0. On rx_rdy, pulse rd_valid with rd_data=rx_out and rd_index=count, then increment count. When count reaches len, go to STOP.
- STOP: stop=1, then wait until the transceiver is idle.
- RELEASE: pulse driver_done and done in the same cycle, with nak valid. busy drops the next cycle.
- driver_cin is all-zero in every cycle that does not issue a command.
- Reset mid-transaction returns the block to IDLE immediately with all outputs zeroed. The arbiter and transceiver must share this reset domain.

## Timing
- Cycle 0: start accepted. Cycle 1: busy=1, driver_request=1. The first bus command is issued the cycle after driver_ack.
- Command fields are single-cycle pulses and never overlap.
- rd_valid is registered: it fires one cycle after the rx_rdy cycle. It never coincides with done.
- done is not asserted before the transceiver reports the stop complete (busy=0).
- A start pulse in the done cycle is ignored. A new start is accepted from the first cycle with busy=0.

## Test plan
- Read 2 bytes: dev 0x50, reg 0x10, slave ACKs all and returns 0xA5, 0x3C. Required: tx bytes 0xA0, 0x10, 0xA1; rd_valid ×2 with (0,0xA5),(1,0x3C); last rx_ack=0; done with nak=0; driver_done coincident with done.
- Address NAK on ADDR_W: required sequence is start, tx 0xA0, stop. done with nak=1, zero rd_valid, no restart issued.
- Register NAK: required sequence is start, tx 0xA0, tx 0x10, stop. done with nak=1.
- Delayed grant: driver_ack withheld for 50 cycles. Required: driver_cin all-zero until the cycle after the ack, and a single driver_request pulse.
- len=0 and a start while busy: len=0 gives done one cycle later with no driver_request. A second start mid-transaction is ignored and the first transaction's dev/reg/len are unchanged.
- Reset asserted during READ: all outputs 0 immediately. After release, a new transaction completes normally.
